// File: rtl/zquench_pkg.sv
// Shared types and default sizes for the SPAD quench/reset sequencer array.
package zquench_pkg;

    // Per-channel sequencer phases: armed, quenching, hold-off, recharging.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUENCH = 2'd1,
        ST_DEAD   = 2'd2,
        ST_RESET  = 2'd3
    } zq_state_e;

    localparam int NCH_DEF         = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DCNT_W_DEF      = 16;

endpackage

// File: rtl/zquench_channel.sv
// One SPAD channel: pulse synchroniser, rising-edge detect, quench/dead/reset
// sequencer with latched durations, and a saturating detection counter.
module zquench_channel
    import zquench_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DCNT_W      = DCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              pulse_i,
    input  logic [CNT_W-1:0]  quench_cycles_i,
    input  logic [CNT_W-1:0]  dead_cycles_i,
    input  logic [CNT_W-1:0]  reset_cycles_i,
    input  logic              cnt_clr_i,
    output logic              quench_o,
    output logic              reset_o,
    output logic              busy_o,
    output logic              det_strobe_o,
    output logic [DCNT_W-1:0] det_count_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    zq_state_e              state_q, state_d;
    logic [CNT_W-1:0]       dur_q, dur_d;
    logic [CNT_W-1:0]       q_len_q, d_len_q, r_len_q;
    logic                   accept;

    logic                   quench_q, quench_d;
    logic                   reset_q, reset_d;
    logic                   busy_q, busy_d;
    logic                   strobe_q;
    logic [DCNT_W-1:0]      count_q;

    // Synchroniser and previous-sample flop; disabled channels hold the chain low.
    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // State, phase counter, latched durations and registered switch drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dur_q    <= '0;
            q_len_q  <= '0;
            d_len_q  <= '0;
            r_len_q  <= '0;
            quench_q <= 1'b0;
            reset_q  <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dur_q    <= dur_d;
            quench_q <= quench_d;
            reset_q  <= reset_d;
            busy_q   <= busy_d;
            strobe_q <= accept;
            if (accept) begin
                // Zero widths for quench/reset are stretched to one cycle.
                q_len_q <= (quench_cycles_i == '0) ? CNT_W'(1) : quench_cycles_i;
                d_len_q <= dead_cycles_i;
                r_len_q <= (reset_cycles_i == '0) ? CNT_W'(1) : reset_cycles_i;
            end
        end
    end

    // Next-state: phase counter runs 1..len in each busy phase; edges only count when armed.
    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        accept  = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            dur_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_QUENCH;
                        dur_d   = CNT_W'(1);
                        accept  = 1'b1;
                    end
                end
                ST_QUENCH: begin
                    if (dur_q == q_len_q) begin
                        state_d = (d_len_q == '0) ? ST_RESET : ST_DEAD;
                        dur_d   = CNT_W'(1);
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (dur_q == d_len_q) begin
                        state_d = ST_RESET;
                        dur_d   = CNT_W'(1);
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
                ST_RESET: begin
                    if (dur_q == r_len_q) begin
                        state_d = ST_IDLE;
                        dur_d   = '0;
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dur_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the drives are registered alongside it.
    always_comb begin
        quench_d = (state_d == ST_QUENCH);
        reset_d  = (state_d == ST_RESET);
        busy_d   = (state_d != ST_IDLE);
    end

    // Detection counter follows the strobe by one cycle; clear beats increment; saturates.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr_i) begin
            count_q <= '0;
        end else if (strobe_q && !(&count_q)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign quench_o     = quench_q;
    assign reset_o      = reset_q;
    assign busy_o       = busy_q;
    assign det_strobe_o = strobe_q;
    assign det_count_o  = count_q;

endmodule

// File: rtl/zquench_array.sv
// Array of independent SPAD quench/reset channels plus registered enable mirror.
module zquench_array
    import zquench_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DCNT_W      = DCNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        en,
    input  logic [NCH-1:0]        pulse,
    input  logic [CNT_W-1:0]      quench_cycles,
    input  logic [CNT_W-1:0]      dead_cycles,
    input  logic [CNT_W-1:0]      reset_cycles,
    input  logic                  cnt_clr,
    output logic [NCH-1:0]        geiger_mode_en,
    output logic [NCH-1:0]        quench,
    output logic [NCH-1:0]        reset,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        det_strobe,
    output logic [NCH*DCNT_W-1:0] det_count
);

    logic [NCH-1:0] geiger_q;

    // Registered copy of the per-channel enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            geiger_q <= '0;
        end else begin
            geiger_q <= en;
        end
    end

    assign geiger_mode_en = geiger_q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            zquench_channel #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES),
                .DCNT_W      (DCNT_W)
            ) u_ch (
                .clk             (clk),
                .rst             (rst),
                .en_i            (en[gi]),
                .pulse_i         (pulse[gi]),
                .quench_cycles_i (quench_cycles),
                .dead_cycles_i   (dead_cycles),
                .reset_cycles_i  (reset_cycles),
                .cnt_clr_i       (cnt_clr),
                .quench_o        (quench[gi]),
                .reset_o         (reset[gi]),
                .busy_o          (busy[gi]),
                .det_strobe_o    (det_strobe[gi]),
                .det_count_o     (det_count[gi*DCNT_W +: DCNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_zquench_array.sv
// Self-checking bench for zquench_array: timeline-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_zquench_array;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int S    = 2;
    localparam int DW   = 4;
    localparam int CMAX = (1 << DW) - 1;

    logic                 clk;
    logic                 rst;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       pulse;
    logic [CW-1:0]        qc, dc, rc;
    logic                 cnt_clr;
    logic [NCH-1:0]       geiger_mode_en, quench, reset, busy, det_strobe;
    logic [NCH*DW-1:0]    det_count;

    zquench_array #(.NCH(NCH), .CNT_W(CW), .SYNC_STAGES(S), .DCNT_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .pulse          (pulse),
        .quench_cycles  (qc),
        .dead_cycles    (dc),
        .reset_cycles   (rc),
        .cnt_clr        (cnt_clr),
        .geiger_mode_en (geiger_mode_en),
        .quench         (quench),
        .reset          (reset),
        .busy           (busy),
        .det_strobe     (det_strobe),
        .det_count      (det_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: delayed pulse history plus "time since detection" per channel.
    logic [S:0] m_dly [NCH];
    bit         m_act [NCH];
    int         m_t   [NCH];
    int         m_ql  [NCH];
    int         m_dl  [NCH];
    int         m_rl  [NCH];
    bit         m_str [NCH];
    int         m_cnt [NCH];
    bit         m_gm  [NCH];

    task automatic chk(input string name, input int ch, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s ch=%0d cyc=%0d got=%0d exp=%0d", name, ch, cyc, got, exp);
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < NCH; c++) begin
            bit ps;
            bit rise;
            ps   = m_str[c];
            rise = m_dly[c][S-1] & ~m_dly[c][S];
            if (rst) begin
                m_dly[c] = '0; m_act[c] = 0; m_t[c] = 0;
                m_str[c] = 0;  m_cnt[c] = 0; m_gm[c] = 0;
            end else begin
                m_gm[c]  = en[c];
                m_str[c] = 0;
                if (!en[c]) begin
                    m_dly[c] = '0;
                    m_act[c] = 0;
                end else begin
                    m_dly[c] = {m_dly[c][S-1:0], pulse[c]};
                    if (m_act[c]) begin
                        m_t[c]++;
                        if (m_t[c] >= m_ql[c] + m_dl[c] + m_rl[c]) m_act[c] = 0;
                    end else if (rise) begin
                        m_act[c] = 1;
                        m_t[c]   = 0;
                        m_ql[c]  = (qc == 0) ? 1 : int'(qc);
                        m_dl[c]  = int'(dc);
                        m_rl[c]  = (rc == 0) ? 1 : int'(rc);
                        m_str[c] = 1;
                    end
                end
                if (cnt_clr) m_cnt[c] = 0;
                else if (ps && m_cnt[c] < CMAX) m_cnt[c]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            int eq, er;
            eq = (m_act[c] && m_t[c] < m_ql[c]) ? 1 : 0;
            er = (m_act[c] && m_t[c] >= m_ql[c] + m_dl[c]) ? 1 : 0;
            chk("quench", c, int'(quench[c]), eq);
            chk("reset", c, int'(reset[c]), er);
            chk("busy", c, int'(busy[c]), int'(m_act[c]));
            chk("det_strobe", c, int'(det_strobe[c]), int'(m_str[c]));
            chk("det_count", c, int'(det_count[c*DW +: DW]), m_cnt[c]);
            chk("geiger_mode_en", c, int'(geiger_mode_en[c]), int'(m_gm[c]));
            chk("no_overlap", c, int'(quench[c] & reset[c]), 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
        cyc++;
    endtask

    task automatic run_measure(input int ch, input int n,
                               output int nq, output int nd, output int nr, output int ns);
        nq = 0; nd = 0; nr = 0; ns = 0;
        repeat (n) begin
            step();
            nq += int'(quench[ch]);
            nr += int'(reset[ch]);
            nd += int'(busy[ch] & ~quench[ch] & ~reset[ch]);
            ns += int'(det_strobe[ch]);
        end
    endtask

    // which: 0=quench 1=reset 2=det_strobe; bounded wait, timeout is a failed check.
    task automatic wait_for(input int which, input int ch, input int bound);
        int k;
        logic v;
        k = 0;
        v = (which == 0) ? quench[ch] : (which == 1) ? reset[ch] : det_strobe[ch];
        while (!v && k < bound) begin
            step();
            k++;
            v = (which == 0) ? quench[ch] : (which == 1) ? reset[ch] : det_strobe[ch];
        end
        chk("wait_event", ch, int'(v), 1);
    endtask

    initial begin
        int nq, nd, nr, ns, nq2, nd2, nr2, ns2;
        for (int c = 0; c < NCH; c++) begin
            m_dly[c] = '0; m_act[c] = 0; m_t[c] = 0; m_ql[c] = 1; m_dl[c] = 0;
            m_rl[c] = 1; m_str[c] = 0; m_cnt[c] = 0; m_gm[c] = 0;
        end
        rst = 1'b1; en = '0; pulse = '0; qc = 8'd3; dc = 8'd2; rc = 8'd4; cnt_clr = 1'b0;
        repeat (3) step();
        chk("reset_state", 0, int'({quench, reset, busy, det_strobe, geiger_mode_en}), 0);
        chk("reset_count", 0, int'(det_count), 0);
        rst = 1'b0; en = '1;
        repeat (2) step();

        // 1: q=3 d=2 r=4 on ch0 only
        pulse[0] = 1'b1; step(); step(); pulse[0] = 1'b0;
        run_measure(0, 18, nq, nd, nr, ns);
        chk("t1_quench_len", 0, nq, 3);
        chk("t1_dead_len", 0, nd, 2);
        chk("t1_reset_len", 0, nr, 4);
        chk("t1_count", 0, int'(det_count[DW-1:0]), 1);
        chk("t1_others_idle", 1, int'(det_count[NCH*DW-1:DW]), 0);

        // 2: zero widths -> 1 quench then 1 reset, no gap
        qc = 0; dc = 0; rc = 0;
        pulse[0] = 1'b1; step(); step(); pulse[0] = 1'b0;
        run_measure(0, 8, nq, nd, nr, ns);
        chk("t2_quench_len", 0, nq, 1);
        chk("t2_dead_len", 0, nd, 0);
        chk("t2_reset_len", 0, nr, 1);

        // 3: re-pulse during DEAD on ch1 ignored; held-high pulse does not retrigger
        qc = 3; dc = 5; rc = 4;
        pulse[1] = 1'b1; repeat (4) step();
        pulse[1] = 1'b0; repeat (2) step();
        pulse[1] = 1'b1;
        run_measure(1, 25, nq, nd, nr, ns);
        chk("t3_no_strobe", 1, ns, 0);
        chk("t3_count", 1, int'(det_count[DW +: DW]), 1);
        pulse[1] = 1'b0; repeat (3) step();

        // 4: quench width changed mid-QUENCH on ch3 affects the next sequence only
        qc = 3; dc = 1; rc = 1;
        pulse[3] = 1'b1;
        run_measure(3, 4, nq, nd, nr, ns);
        qc = 6;
        run_measure(3, 10, nq2, nd2, nr2, ns2);
        chk("t4_first_quench", 3, nq + nq2, 3);
        pulse[3] = 1'b0; repeat (2) step();
        pulse[3] = 1'b1;
        run_measure(3, 15, nq, nd, nr, ns);
        chk("t4_second_quench", 3, nq, 6);
        pulse[3] = 1'b0; repeat (2) step();

        // 5a: en[2] dropped during QUENCH
        qc = 5; dc = 1; rc = 2;
        pulse[2] = 1'b1;
        wait_for(0, 2, 10);
        en[2] = 1'b0; step();
        chk("t5_quench_off", 2, int'(quench[2]), 0);
        chk("t5_busy_off", 2, int'(busy[2]), 0);
        chk("t5_geiger_off", 2, int'(geiger_mode_en[2]), 0);
        en[2] = 1'b1; pulse[2] = 1'b0; repeat (3) step();

        // 5b: rst during RESET phase
        rc = 8; pulse[0] = 1'b1;
        wait_for(1, 0, 30);
        rst = 1'b1; step();
        chk("t5_rst_outs", 0, int'({quench, reset, busy, det_strobe, geiger_mode_en}), 0);
        chk("t5_rst_count", 0, int'(det_count), 0);
        rst = 1'b0; pulse[0] = 1'b0; repeat (3) step();

        // 6: saturation and clear-beats-increment
        qc = 0; dc = 0; rc = 0;
        repeat (17) begin
            pulse[0] = 1'b1; step();
            pulse[0] = 1'b0; repeat (5) step();
        end
        repeat (2) step();
        chk("t6_saturate", 0, int'(det_count[DW-1:0]), 15);
        pulse[0] = 1'b1;
        wait_for(2, 0, 10);
        cnt_clr = 1'b1; step();
        chk("t6_clr_wins", 0, int'(det_count[DW-1:0]), 0);
        cnt_clr = 1'b0; pulse[0] = 1'b0; repeat (2) step();
        chk("t6_clr_held", 0, int'(det_count[DW-1:0]), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                qc = CW'($urandom_range(0, 6));
                dc = CW'($urandom_range(0, 6));
                rc = CW'($urandom_range(0, 6));
            end
            rst     = ($urandom_range(0, 499) == 0);
            cnt_clr = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 63) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 3) == 0) pulse[c] = ~pulse[c];
            end
            step();
        end
        rst = 1'b0; cnt_clr = 1'b0; pulse = '0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
